// File: rtl/wd_pkg.sv
// Shared constants for the multi-channel watchdog APB register block:
// register offsets, unlock/feed keys, CTRL/STATUS bit positions and the
// read-response FSM state type.
package wd_pkg;

  localparam logic [3:0]  OFF_LOAD   = 4'h0;
  localparam logic [3:0]  OFF_CTRL   = 4'h4;
  localparam logic [3:0]  OFF_FEED   = 4'h8;
  localparam logic [3:0]  OFF_STATUS = 4'hC;

  localparam logic [7:0]  ADDR_LOCK  = 8'h80;
  localparam logic [7:0]  ADDR_ID    = 8'h84;
  localparam logic [7:0]  ADDR_ERR   = 8'h88;  // first offset of the error hole

  localparam logic [31:0] LOCK_KEY   = 32'h1ACC_E551;
  localparam logic [31:0] FEED_KEY   = 32'h5A5A_A5A5;

  localparam int unsigned CTRL_IE    = 3;
  localparam int unsigned CTRL_EN    = 2;
  localparam int unsigned ST_FERR    = 1;
  localparam int unsigned ST_EXP     = 0;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

endpackage

// File: rtl/wd_apb_mc_if.sv
// APB bus bundle for wd_apb_mc.
// slave : psel/penable/pwrite/paddr/pwdata in; prdata/pready/pslverr out.
// master: mirror image, used by the bench.
interface wd_apb_mc_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport slave  (input psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input prdata, pready, pslverr);
endinterface

// File: rtl/wd_ch_regs.sv
// Register set of one watchdog channel: LOAD, CTRL, FEED and STATUS.
// Inputs : clk, rst (sync, high), per-register write strobes already
//          qualified by decode/lock, wdata, timeout expiry pulse.
// Outputs: load value, ie/en/mode, expired/feed_err, feed/update pulses.
module wd_ch_regs
  import wd_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_load,
  input  logic             we_ctrl,
  input  logic             we_feed,
  input  logic             we_status,
  input  logic [31:0]      wdata,
  input  logic             timeout,
  output logic [CNT_W-1:0] load,
  output logic             ie,
  output logic             en,
  output logic [1:0]       mode,
  output logic             expired,
  output logic             feed_err,
  output logic             feed,
  output logic             update
);

  logic key_ok;
  assign key_ok = (wdata == FEED_KEY);

  always_ff @(posedge clk) begin
    if (rst) begin
      load     <= '1;
      ie       <= 1'b0;
      en       <= 1'b0;
      mode     <= 2'b10;
      expired  <= 1'b0;
      feed_err <= 1'b0;
      feed     <= 1'b0;
      update   <= 1'b0;
    end else begin
      // Pulses are re-evaluated every cycle, so they last exactly one cycle.
      update <= we_load;
      feed   <= we_feed & key_ok;
      if (we_load) load <= wdata[CNT_W-1:0];
      if (we_ctrl) begin
        ie   <= wdata[CTRL_IE];
        en   <= wdata[CTRL_EN];
        mode <= wdata[1:0];
      end
      // A set in the same cycle as a W1C clear wins.
      expired  <= timeout | (expired & ~(we_status & wdata[ST_EXP]));
      feed_err <= (we_feed & ~key_ok) | (feed_err & ~(we_status & wdata[ST_FERR]));
    end
  end

endmodule

// File: rtl/wd_apb_mc.sv
// Multi-channel watchdog APB register block.
// Ports: pclk/prst (sync active-high reset), apb (APB slave bundle),
//        timeout[NUM_CH] in; feed/update pulses, ch_en, mode (2b/ch),
//        start_value (CNT_W/ch), irq (registered level) out.
// Writes complete with zero wait states; reads take one wait state.
module wd_apb_mc
  import wd_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    pclk,
  input  logic                    prst,
  wd_apb_mc_if.slave              apb,
  input  logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       feed,
  output logic [NUM_CH-1:0]       update,
  output logic [NUM_CH-1:0]       ch_en,
  output logic [2*NUM_CH-1:0]     mode,
  output logic [NUM_CH*CNT_W-1:0] start_value,
  output logic                    irq
);

  rd_state_t   state, state_nx;
  logic        locked, rd_err_q;
  logic [31:0] prdata_q, rd_val;

  logic [2:0]  ch_idx;
  logic [3:0]  off;
  logic        ch_ok, range_err, wr, rd_start, wr_err, wr_ok;

  // Channel views padded to 8 entries so any 3-bit index is in range.
  logic [CNT_W-1:0] load_a [8];
  logic [3:0]       ctrl_a [8];
  logic [1:0]       stat_a [8];
  logic [7:0]       irq_src;

  assign ch_idx    = apb.paddr[6:4];
  assign off       = apb.paddr[3:0];
  assign ch_ok     = !apb.paddr[7] && (32'(ch_idx) < NUM_CH);
  assign range_err = (!apb.paddr[7] && !ch_ok) || (apb.paddr >= ADDR_ERR);
  assign wr        = apb.psel && apb.penable && apb.pwrite;
  assign rd_start  = apb.psel && apb.penable && !apb.pwrite && (state == RD_IDLE);
  assign wr_err    = range_err || (apb.paddr == ADDR_ID) ||
                     (locked && ch_ok && ((off == OFF_LOAD) || (off == OFF_CTRL)));
  assign wr_ok     = wr && !wr_err;

  for (genvar n = 0; n < 8; n++) begin : g_ch
    if (n < NUM_CH) begin : g_on
      logic sel, ie, en, expired, feed_err;
      logic [1:0] md;
      assign sel = wr_ok && ch_ok && (32'(ch_idx) == n);
      wd_ch_regs #(.CNT_W(CNT_W)) u_regs (
        .clk      (pclk),
        .rst      (prst),
        .we_load  (sel && (off == OFF_LOAD)),
        .we_ctrl  (sel && (off == OFF_CTRL)),
        .we_feed  (sel && (off == OFF_FEED)),
        .we_status(sel && (off == OFF_STATUS)),
        .wdata    (apb.pwdata),
        .timeout  (timeout[n]),
        .load     (load_a[n]),
        .ie       (ie),
        .en       (en),
        .mode     (md),
        .expired  (expired),
        .feed_err (feed_err),
        .feed     (feed[n]),
        .update   (update[n])
      );
      assign ctrl_a[n]                   = {ie, en, md};
      assign stat_a[n]                   = {feed_err, expired};
      assign irq_src[n]                  = ie & (expired | feed_err);
      assign ch_en[n]                    = en;
      assign mode[2*n +: 2]              = md;
      assign start_value[n*CNT_W +: CNT_W] = load_a[n];
    end else begin : g_off
      assign load_a[n]  = '0;
      assign ctrl_a[n]  = '0;
      assign stat_a[n]  = '0;
      assign irq_src[n] = 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    if (ch_ok) begin
      case (off)
        OFF_LOAD:   rd_val[CNT_W-1:0] = load_a[ch_idx];
        OFF_CTRL:   rd_val[3:0]       = ctrl_a[ch_idx];
        OFF_STATUS: rd_val[1:0]       = stat_a[ch_idx];
        default:    rd_val            = '0;
      endcase
    end else if (apb.paddr == ADDR_LOCK) begin
      rd_val[0] = locked;
    end else if (apb.paddr == ADDR_ID) begin
      rd_val = {16'h0, 8'(NUM_CH), 8'(CNT_W)};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RD_IDLE: if (rd_start) state_nx = RD_RESP;
      RD_RESP: state_nx = RD_IDLE;
      default: state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state    <= RD_IDLE;
      locked   <= 1'b1;
      prdata_q <= '0;
      rd_err_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state <= state_nx;
      irq   <= |irq_src;
      if (wr && (apb.paddr == ADDR_LOCK)) locked <= (apb.pwdata != LOCK_KEY);
      if (rd_start) begin
        prdata_q <= range_err ? 32'h0 : rd_val;
        rd_err_q <= range_err;
      end
    end
  end

  // Reset gates pready so an abandoned read never completes.
  always_comb begin
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    if (!prst) begin
      if (wr) begin
        apb.pready  = 1'b1;
        apb.pslverr = wr_err;
      end else if ((state == RD_RESP) && apb.psel && apb.penable) begin
        apb.pready  = 1'b1;
        apb.pslverr = rd_err_q;
      end
    end
  end

  assign apb.prdata = prdata_q;

endmodule

// File: tb/tb_wd_apb_mc.sv
// Directed bench for wd_apb_mc (NUM_CH = 4, CNT_W = 32): a vector table of
// APB accesses plus hand-written sequences for pulses, irq and reset.
module tb_wd_apb_mc;

  logic         pclk = 1'b0;
  logic         prst;
  logic [3:0]   timeout;
  logic [3:0]   feed, update, ch_en;
  logic [7:0]   mode;
  logic [127:0] start_value;
  logic         irq;

  int n_cmp  = 0;
  int n_fail = 0;

  wd_apb_mc_if apb();

  wd_apb_mc #(.NUM_CH(4), .CNT_W(32)) dut (
    .pclk       (pclk),
    .prst       (prst),
    .apb        (apb),
    .timeout    (timeout),
    .feed       (feed),
    .update     (update),
    .ch_en      (ch_en),
    .mode       (mode),
    .start_value(start_value),
    .irq        (irq)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = a; apb.pwdata = d;
    @(posedge pclk); #1 apb.penable = 1'b1;
    @(negedge pclk);
    chk("wr_pready", {31'b0, apb.pready}, 32'h1);
    err = apb.pslverr;
    @(posedge pclk); #1 bus_idle();
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err,
                          output int waits);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
    @(posedge pclk); #1 apb.penable = 1'b1;
    waits = 0;
    @(negedge pclk);
    while (!apb.pready && waits < 8) begin
      waits++;
      @(negedge pclk);
    end
    if (!apb.pready) chk("rd_timeout", 32'h0, 32'h1);
    d = apb.prdata; err = apb.pslverr;
    @(posedge pclk); #1 bus_idle();
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d; logic e; int w;
    apb_read(a, d, e, w);
    chk(nm, d, exp);
  endtask

  task automatic wr_chk(input string nm, input logic [7:0] a, input logic [31:0] d,
                        input logic exp_err);
    logic e;
    apb_write(a, d, e);
    chk(nm, {31'b0, e}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] d; logic e; int w;

    tbl.push_back('{1'b0, 8'h00, 32'h0,          32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b0, 8'h04, 32'h0,          32'h0000_0002, 1'b0});
    tbl.push_back('{1'b0, 8'h80, 32'h0,          32'h0000_0001, 1'b0});
    tbl.push_back('{1'b0, 8'h84, 32'h0,          32'h0000_0420, 1'b0});
    tbl.push_back('{1'b0, 8'h08, 32'h0,          32'h0,         1'b0});
    tbl.push_back('{1'b0, 8'h40, 32'h0,          32'h0,         1'b1});
    tbl.push_back('{1'b0, 8'h90, 32'h0,          32'h0,         1'b1});
    tbl.push_back('{1'b1, 8'h84, 32'h0,          32'h0,         1'b1});
    tbl.push_back('{1'b1, 8'h10, 32'h1234,       32'h0,         1'b1});
    tbl.push_back('{1'b0, 8'h10, 32'h0,          32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{1'b1, 8'h14, 32'hF,          32'h0,         1'b1});
    tbl.push_back('{1'b0, 8'h14, 32'h0,          32'h0000_0002, 1'b0});
    tbl.push_back('{1'b1, 8'h80, 32'h1ACC_E551,  32'h0,         1'b0});
    tbl.push_back('{1'b0, 8'h80, 32'h0,          32'h0,         1'b0});
    tbl.push_back('{1'b1, 8'h14, 32'hD,          32'h0,         1'b0});
    tbl.push_back('{1'b0, 8'h14, 32'h0,          32'h0000_000D, 1'b0});
    tbl.push_back('{1'b0, 8'h86, 32'h0,          32'h0,         1'b0});

    bus_idle(); apb.paddr = '0; apb.pwdata = '0; timeout = '0;
    prst = 1'b1;
    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;
    @(negedge pclk);
    chk("rst_prdata", apb.prdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_mode", {24'b0, mode}, 32'h0000_00AA);
    chk("rst_sv_ones", {31'b0, &start_value}, 32'h1);
    chk("rst_pready_idle", {30'b0, apb.pready, apb.pslverr}, 32'h0);
    @(posedge pclk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) begin
        apb_write(tbl[i].addr, tbl[i].wdata, e);
        chk($sformatf("v%0d_wr_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
      end else begin
        apb_read(tbl[i].addr, d, e, w);
        chk($sformatf("v%0d_rd_data", i), d, tbl[i].exp_data);
        chk($sformatf("v%0d_rd_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
        chk($sformatf("v%0d_rd_waits", i), 32'(w), 32'd1);
      end
    end
    chk("ch_en_after_ctrl", {28'b0, ch_en}, 32'h2);
    chk("mode_after_ctrl", {24'b0, mode}, 32'h0000_00A6);

    // LOAD write while unlocked: update[1] high for one cycle.
    wr_chk("load1_err", 8'h10, 32'h1234, 1'b0);
    @(negedge pclk); chk("update_pulse", {28'b0, update}, 32'h2);
    @(negedge pclk); chk("update_clear", {28'b0, update}, 32'h0);
    chk("start_value1", start_value[63:32], 32'h1234);
    rd_chk("load1_rb", 8'h10, 32'h1234);

    // Relock with a non-key value; LOAD writes fail again.
    wr_chk("relock_err", 8'h80, 32'h0, 1'b0);
    rd_chk("relock_rb", 8'h80, 32'h1);
    wr_chk("load0_locked", 8'h00, 32'h55, 1'b1);
    rd_chk("load0_kept", 8'h00, 32'hFFFF_FFFF);

    // Feed keys (lock is ignored for FEED).
    wr_chk("feed_ok_err", 8'h28, 32'h5A5A_A5A5, 1'b0);
    @(negedge pclk); chk("feed_pulse", {28'b0, feed}, 32'h4);
    @(negedge pclk); chk("feed_clear", {28'b0, feed}, 32'h0);
    rd_chk("status2_clean", 8'h2C, 32'h0);
    wr_chk("feed_bad_err", 8'h28, 32'h0, 1'b0);
    @(negedge pclk); chk("feed_bad_nopulse", {28'b0, feed}, 32'h0);
    rd_chk("status2_ferr", 8'h2C, 32'h2);
    chk("irq_ie_off", {31'b0, irq}, 32'h0);

    // Enable ie[0], expire channel 0, irq one cycle after expired.
    wr_chk("unlock2", 8'h80, 32'h1ACC_E551, 1'b0);
    wr_chk("ctrl0_ie", 8'h04, 32'h8, 1'b0);
    timeout = 4'b0001;
    @(posedge pclk); #1 timeout = '0;
    @(negedge pclk); chk("irq_latency", {31'b0, irq}, 32'h0);
    @(negedge pclk); chk("irq_set", {31'b0, irq}, 32'h1);

    // W1C of expired in the same cycle as a new timeout: set wins.
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 8'h0C; apb.pwdata = 32'h1;
    @(posedge pclk); #1 apb.penable = 1'b1; timeout = 4'b0001;
    @(negedge pclk); chk("w1c_race_pready", {31'b0, apb.pready}, 32'h1);
    @(posedge pclk); #1 bus_idle(); timeout = '0;
    rd_chk("status0_set_wins", 8'h0C, 32'h1);
    wr_chk("w1c_err", 8'h0C, 32'h1, 1'b0);
    rd_chk("status0_cleared", 8'h0C, 32'h0);
    @(negedge pclk); chk("irq_cleared", {31'b0, irq}, 32'h0);
    @(posedge pclk); #1;

    // Reset during the read wait cycle: no pready, reset values restored.
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 8'h14;
    @(posedge pclk); #1 apb.penable = 1'b1;
    @(negedge pclk); chk("mid_wait_pready", {31'b0, apb.pready}, 32'h0);
    @(posedge pclk); #1 prst = 1'b1;
    @(negedge pclk); chk("mid_rst_pready", {31'b0, apb.pready}, 32'h0);
    @(posedge pclk); #1 prst = 1'b0; bus_idle();
    @(negedge pclk);
    chk("mid_rst_pready_after", {31'b0, apb.pready}, 32'h0);
    chk("mid_rst_prdata", apb.prdata, 32'h0);
    chk("mid_rst_ch_en", {28'b0, ch_en}, 32'h0);
    chk("mid_rst_mode", {24'b0, mode}, 32'h0000_00AA);
    chk("mid_rst_sv", {31'b0, &start_value}, 32'h1);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    chk("mid_rst_pulses", {24'b0, feed, update}, 32'h0);
    @(posedge pclk); #1;
    rd_chk("mid_rst_lock", 8'h80, 32'h1);
    rd_chk("mid_rst_load0", 8'h00, 32'hFFFF_FFFF);
    rd_chk("mid_rst_status2", 8'h2C, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
